// File: rtl/arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter: FSM state type,
// sizing constants and a one-hot helper.
package arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] one_s;
        one_s = N_REQ'(1);
        return one_s << idx;
    endfunction

endpackage

// File: rtl/arbiter8to3_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arbiter8to3_if;
    import arbiter_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] y;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output en, req,
        input  gnt, y, gnt_valid, timeout
    );

    modport slave (
        input  en, req,
        output gnt, y, gnt_valid, timeout
    );
endinterface

// File: rtl/pri_enc8to3.sv
// Combinational 8-to-3 priority encoder: lowest set index wins, valid when any bit set.
module pri_enc8to3
    import arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest asserted bit is written last.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/arbiter8to3.sv
// Round-robin 8-requester arbiter with per-grant hold limit, mandatory idle
// turnaround between grants and registered one-hot / encoded outputs.
module arbiter8to3
    import arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter8to3_if.slave  bus
);

    localparam logic       HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t           state_r, state_s;
    logic [N_REQ-1:0] gnt_r, gnt_s;
    logic [IDX_W-1:0] y_r, y_s;
    logic             valid_r, valid_s;
    logic             timeout_r, timeout_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [7:0]       hold_r, hold_s;

    logic [N_REQ-1:0] rot_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_valid_s;
    logic [IDX_W-1:0] win_s;

    // Rotate so that requester ptr lands on bit 0; a shift by 8 yields zero.
    assign rot_s = (bus.req >> ptr_r) | (bus.req << (4'd8 - {1'b0, ptr_r}));

    pri_enc8to3 u_enc (
        .in_vec (rot_s),
        .idx    (enc_idx_s),
        .valid  (enc_valid_s)
    );

    assign win_s = enc_idx_s + ptr_r;

    // Next-state logic: grant from IDLE, hold/release/revoke from BUSY.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        y_s       = y_r;
        valid_s   = valid_r;
        timeout_s = 1'b0;
        ptr_s     = ptr_r;
        hold_s    = hold_r;
        case (state_r)
            IDLE: begin
                if (bus.en && enc_valid_s) begin
                    state_s = BUSY;
                    gnt_s   = idx_to_onehot(win_s);
                    y_s     = win_s;
                    valid_s = 1'b1;
                    hold_s  = 8'd0;
                end else begin
                    gnt_s   = 8'h00;
                    y_s     = 3'd0;
                    valid_s = 1'b0;
                end
            end
            BUSY: begin
                if (!bus.req[y_r] || (HOLD_EN && (hold_r == HOLD_LAST))) begin
                    // Release wins over expiry, so timeout only when req is still up.
                    state_s   = IDLE;
                    gnt_s     = 8'h00;
                    y_s       = 3'd0;
                    valid_s   = 1'b0;
                    ptr_s     = y_r + 3'd1;
                    timeout_s = bus.req[y_r];
                end else begin
                    hold_s = hold_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 8'h00;
                y_s     = 3'd0;
                valid_s = 1'b0;
                ptr_s   = 3'd0;
                hold_s  = 8'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            gnt_r     <= 8'h00;
            y_r       <= 3'd0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            ptr_r     <= 3'd0;
            hold_r    <= 8'd0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            y_r       <= y_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
            ptr_r     <= ptr_s;
            hold_r    <= hold_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.y         = y_r;
    assign bus.gnt_valid = valid_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_arbiter8to3.sv
// Directed plus randomized checks of arbiter8to3 (MAX_HOLD=4) against a
// cycle-count based round-robin reference model.
module tb_arbiter8to3;

    localparam int MAXH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference model: current grantee (-1 = none), cycles shown, search start.
    int   m_g;
    int   m_held;
    int   m_ptr;
    logic m_to;

    arbiter8to3_if bus ();

    arbiter8to3 #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        m_g    = -1;
        m_held = 0;
        m_ptr  = 0;
        m_to   = 1'b0;
    endfunction

    function automatic void model_update(input logic e, input logic [7:0] r);
        int ng;
        int idx;
        ng   = m_g;
        m_to = 1'b0;
        if (m_g < 0) begin
            if (e && r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    idx = (m_ptr + k) % 8;
                    if (ng < 0 && r[idx]) ng = idx;
                end
                m_held = 1;
            end
        end else if (!r[m_g]) begin
            ng    = -1;
            m_ptr = (m_g + 1) % 8;
        end else if (MAXH != 0 && m_held == MAXH) begin
            ng    = -1;
            m_ptr = (m_g + 1) % 8;
            m_to  = 1'b1;
        end else begin
            m_held++;
        end
        m_g = ng;
    endfunction

    task automatic compare_model(input string tag);
        logic [7:0] eg;
        logic [7:0] ey;
        eg = 8'h00;
        ey = 8'h00;
        if (m_g >= 0) begin
            eg[m_g] = 1'b1;
            ey      = 8'(m_g);
        end
        chk({tag, "_gnt"}, bus.gnt, eg);
        chk({tag, "_y"}, {5'd0, bus.y}, ey);
        chk({tag, "_valid"}, {7'd0, bus.gnt_valid}, {7'd0, (m_g >= 0)});
        chk({tag, "_timeout"}, {7'd0, bus.timeout}, {7'd0, m_to});
    endtask

    task automatic step(input string tag, input logic e, input logic [7:0] r);
        bus.en  = e;
        bus.req = r;
        model_update(e, r);
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    initial begin
        logic [7:0] rreq;
        logic       ren;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        compare_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic grant, release, idle turnaround, next requester 7.
        step("r26a", 1'b1, 8'h81);
        chk("r26_gnt0", bus.gnt, 8'h01);
        step("r26b", 1'b1, 8'h80);
        chk("r26_idle", bus.gnt, 8'h00);
        step("r26c", 1'b1, 8'h80);
        chk("r26_gnt7", bus.gnt, 8'h80);
        chk("r26_y7", {5'd0, bus.y}, 8'd7);

        // Release of 7 wraps the pointer to 0.
        step("r27a", 1'b1, 8'h01);
        step("r27b", 1'b1, 8'h81);
        chk("r27_y0", {5'd0, bus.y}, 8'd0);
        step("r27c", 1'b1, 8'h00);

        // Single requester held: 4 grant cycles, timeout, one idle, re-grant.
        for (int i = 0; i < 12; i++) begin
            step("r28", 1'b1, 8'h04);
            if (i < 4) chk("r28_hold", bus.gnt, 8'h04);
            if (i == 4) begin
                chk("r28_to", {7'd0, bus.timeout}, 8'd1);
                chk("r28_gap", bus.gnt, 8'h00);
            end
            if (i == 5) chk("r28_regrant", {5'd0, bus.y}, 8'd2);
        end
        step("r28z", 1'b1, 8'h00);

        // Two requesters held: alternating 4-cycle grants.
        for (int i = 0; i < 20; i++) step("r29", 1'b1, 8'h14);
        step("r29z", 1'b1, 8'h00);

        // Enable low blocks new grants but not an active one.
        for (int i = 0; i < 3; i++) begin
            step("r30a", 1'b0, 8'hFF);
            chk("r30_blocked", bus.gnt, 8'h00);
        end
        step("r30b", 1'b1, 8'h02);
        step("r30c", 1'b0, 8'h02);
        step("r30d", 1'b0, 8'h02);
        chk("r30_held", bus.gnt, 8'h02);
        step("r30e", 1'b0, 8'h00);

        // Asynchronous reset mid-grant, then restart from pointer 0.
        step("r31a", 1'b1, 8'h20);
        step("r31b", 1'b1, 8'h20);
        chk("r31_y5", {5'd0, bus.y}, 8'd5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model("r31_async");
        @(posedge clk);
        #1;
        compare_model("r31_inreset");
        @(negedge clk);
        rst_n = 1'b1;
        step("r31c", 1'b1, 8'h20);
        chk("r31_regrant", bus.gnt, 8'h20);
        step("r31d", 1'b1, 8'h00);

        // Randomized traffic with sticky request vectors.
        rreq = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rreq = 8'($urandom);
            ren = ($urandom_range(0, 7) != 0);
            step("rand", ren, rreq);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arbiter8to3.md
ARBITER8TO3 -- requirements
Module: arbiter8to3

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive grant cycles per requester (0 = unlimited, legal range 0..255).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state updated on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port en  input  1  arbitration enable; low blocks new grants only.
REQ-005 The block SHALL have port req  input  8  request vector, bit i from requester i, level-held while service is wanted.
REQ-006 The block SHALL have port gnt  output  8  registered one-hot grant, all-zero when no grant.
REQ-007 The block SHALL have port y  output  3  registered encoded index of the granted requester, 3'd0 when no grant.
REQ-008 The block SHALL have port gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-011 In IDLE with en=1 and req!=0, the block SHALL grant, at the next rising edge, the first asserted requester searched from index ptr upward, wrapping 7->0.
REQ-012 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with gnt=0, y=0, gnt_valid=0.
REQ-013 Request-to-grant latency SHALL be exactly 1 clock from the edge at which req is sampled.
REQ-014 In BUSY, gnt, y and gnt_valid SHALL be held constant while req[y]=1 and the hold limit is not reached, regardless of en and other req bits.
REQ-015 In BUSY, when req[y] is sampled 0, the block SHALL return to IDLE at that edge (gnt=0 next cycle) and set ptr=(y+1) mod 8.
REQ-016 A hold counter SHALL clear on each new grant and increment each BUSY cycle; when MAX_HOLD!=0 and the counter reaches MAX_HOLD-1 with req[y] still 1, the block SHALL revoke the grant (return to IDLE), set ptr=(y+1) mod 8, and pulse timeout for one cycle.
REQ-017 Every grant release or revocation SHALL be followed by at least one IDLE cycle with gnt=0 (turnaround), so two different grants are never adjacent.
REQ-018 Pointer wrap: release of requester 7 SHALL set ptr=0.
REQ-019 Simultaneous release and timeout in the same cycle SHALL be treated as release (timeout not pulsed).
REQ-020 A revoked requester keeping req high SHALL be re-granted only after every other asserted requester has been served once (round-robin fairness).
REQ-021 gnt SHALL never have more than one bit set; y SHALL always equal the index of the set bit.

Reset
REQ-022 While rst_n=0 the block SHALL immediately force state=IDLE, gnt=8'h00, y=3'd0, gnt_valid=0, timeout=0, ptr=3'd0, hold counter=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously; after rst_n rises, arbitration SHALL restart from ptr=0 on the first clock edge.

Structure
REQ-024 A shared package arbiter_pkg SHALL hold the FSM state type (IDLE, BUSY), N_REQ=8 and IDX_W=3.
REQ-025 The block SHALL instantiate one sub-module pri_enc8to3: combinational 8-to-3 priority encoder (lowest index wins, valid flag) applied to the request vector rotated by ptr; the result is un-rotated by adding ptr mod 8.

Verification
REQ-026 Reset, then req=8'b1000_0001, en=1 -> gnt=8'h01, y=0 one cycle later; drop req[0] -> one idle cycle, then gnt=8'h80, y=7.
REQ-027 Release of requester 7 with req=8'h81 still asserted -> ptr=0, next grant y=0 (wrap-around).
REQ-028 MAX_HOLD=4, req=8'h04 held constant -> gnt=8'h04 for exactly 4 cycles, timeout pulse at revocation, one idle cycle, re-grant y=2.
REQ-029 MAX_HOLD=4, req=8'h14 held -> grants alternate y=2, y=4, y=2 each lasting 4 cycles with one idle gap.
REQ-030 en=0 with req=8'hFF -> gnt stays 0; en dropped during a BUSY grant -> grant continues until release.
REQ-031 rst_n pulled low mid-grant (y=5) -> gnt=0 immediately without clock; after release, req=8'h20 -> grant y=5 one cycle after first edge.
